countdown_timer: RTL and testbench
==================================

# countdown_timer

Parametrised successor to the bomb controller's fixed one-second timer. Divides the system clock into half-second and one-second tick pulses for any even clock frequency. Adds a loadable seconds countdown with a warning window and an expiry indication. It sits between the controller FSM, which issues enable/clear/load, and the display and alarm logic, which consume the ticks, `seconds_left`, `warn` and `expired`.

## Interface
- `CLK_HZ`, 50_000_000: clock frequency in Hz; must be even and ≥ 2 (`CLK_HZ = 4` in simulation).
- `SEC_W`, 8: width of the countdown value.
- `WARN_SEC`, 10: `warn` window; `seconds_left` ≤ `WARN_SEC` and nonzero.

- `clk` input 1: system clock, rising edge.
- `async_nreset` input 1: asynchronous, active-low reset.
- `enable` input 1: advances the prescaler and countdown while high; freezes both while low.
- `clear` input 1: synchronous clear of prescaler, countdown and flags.
- `load` input 1: synchronous load of `load_value` into the countdown.
- `load_value` input `SEC_W`: initial seconds.
- `half_second_elapsed` output 1: one-cycle pulse every `CLK_HZ/2` enabled cycles.
- `second_elapsed` output 1: one-cycle pulse every `CLK_HZ` enabled cycles.
- `seconds_left` output `SEC_W`: current countdown value.
- `warn` output 1: level, high when 0 < `seconds_left` ≤ `WARN_SEC`.
- `done` output 1: one-cycle pulse when the countdown reaches 0.
- `expired` output 1: level, set with `done`, held until `clear` or `load`.

## Operation
- Prescaler `cnt`, range 0..`CLK_HZ-1`, width `$clog2(CLK_HZ)`.
  - When `enable` is high, `cnt` increments each cycle and wraps from `CLK_HZ-1` to 0.
  - When `enable` is low, `cnt` holds.
- Tick generation, all outputs registered:
  - Enabled cycle with `cnt == CLK_HZ/2-1`: `half_second_elapsed` is high the next cycle.
  - Enabled cycle with `cnt == CLK_HZ-1`: `half_second_elapsed` and `second_elapsed` are both high the next cycle.
- Countdown:
  - On an enabled cycle where `cnt == CLK_HZ-1` and `seconds_left != 0`, `seconds_left` decrements, in the same update as `second_elapsed`.
  - Decrement 1→0: `done` pulses and `expired` is set in that same update.
  - At 0 the counter holds and never wraps. Ticks continue while enabled.
- Priority per cycle: `clear` > `load` > counting.
  - `clear`: `cnt`, `seconds_left`, ticks, `done` and `expired` go to 0.
  - `load`: `cnt` = 0, `seconds_left` = `load_value`, `expired` = 0, no tick and no `done` that cycle. The first decrement after `load` therefore occurs exactly `CLK_HZ` enabled cycles later.
  - `load` with `load_value` = 0: idle, `expired` stays 0, no `done`.
- `clear` and `load` act regardless of `enable`.
- `warn` is decoded from registered `seconds_left` only.

## Timing
- Reset (`async_nreset` low): every output and all internal state are 0 immediately, without waiting for a clock edge.
- Reset release: counting starts on the first rising edge with `enable` high.
- Latency, with `enable` held high after `cnt = 0`:
  - First `half_second_elapsed` is visible in the cycle after the `CLK_HZ/2`-th enabled edge.
  - First `second_elapsed` is visible in the cycle after the `CLK_HZ`-th enabled edge.
- Pulses last exactly one cycle.
  - Dropping `enable` does not stretch or cancel a pulse already registered.
- Reset asserted mid-count aborts without a `done` pulse.

## Structure
- Package `timer_pkg`:
  - Function `cnt_width(hz)`, wrapping `$clog2`.
  - Default constants `CLK_HZ_DEFAULT` and `SEC_W_DEFAULT`.
- Sub-module `tick_prescaler`, parameter `CLK_HZ`:
  - Ports `clk`, `async_nreset`, `enable`, `sync_clear` (driven by `clear | load`).
  - Outputs `half_second_elapsed` and `second_elapsed`.
  - Also exports `wrap`, the pre-register terminal count, used by the countdown.
- `countdown_timer` instantiates `tick_prescaler` and holds the countdown, `warn`, `done` and `expired` logic.
- Add an elaboration-time check that `CLK_HZ` is even and ≥ 2.

## Test plan
All scenarios use `CLK_HZ = 4`, `SEC_W = 8`, `WARN_SEC = 2`, and a 2-time-unit clock period.
- Reset for 5 units, then `clear` for 1 cycle, then `enable` = 1 → `half_second_elapsed` high on enabled cycles 3, 5, 7…; `second_elapsed` high on cycles 5, 9…; `seconds_left` stays 0 and `done` never fires.
- `load` with `load_value` = 3, then enable → `seconds_left` goes 3→2→1→0 at 4-cycle intervals; `warn` is high at 2 and 1 and low at 0; `done` pulses once at the 1→0 update; `expired` then stays high.
- `enable` dropped for 7 cycles mid-second → `cnt` and `seconds_left` freeze, and the next `second_elapsed` is delayed by exactly 7 cycles.
- `load` and `clear` asserted together with `seconds_left` = 5 → all state 0; `load` asserted alone while `expired` = 1 → `expired` clears, `cnt` = 0, and the next decrement comes 4 enabled cycles later.
- `load_value` = 0 → no `done`, `expired` = 0, `warn` = 0, while ticks keep running.
- `async_nreset` pulsed low between clock edges with `seconds_left` = 1 and `cnt` = 3 → all outputs 0 immediately, and no `done` is produced.

Source files
------------

// File: rtl/timer_pkg.sv
// rtl/timer_pkg.sv - shared constants and helpers for the countdown timer
`timescale 1ns/1ps
package timer_pkg;

    localparam int CLK_HZ_DEFAULT = 50_000_000;
    localparam int SEC_W_DEFAULT  = 8;

    function automatic int cnt_width(input int hz);
        return (hz > 1) ? $clog2(hz) : 1;
    endfunction

endpackage

// File: rtl/tick_prescaler.sv
// rtl/tick_prescaler.sv - divides clk into registered half-second and second ticks
`timescale 1ns/1ps
module tick_prescaler
    import timer_pkg::*;
#(
    parameter int CLK_HZ = CLK_HZ_DEFAULT
) (
    input  logic clk,
    input  logic async_nreset,
    input  logic enable,
    input  logic sync_clear,
    output logic half_second_elapsed,
    output logic second_elapsed,
    output logic wrap
);

    localparam int CNT_W = cnt_width(CLK_HZ);
    localparam logic [CNT_W-1:0] LAST      = CNT_W'(CLK_HZ - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLK_HZ / 2 - 1);

    generate
        if ((CLK_HZ % 2) != 0 || CLK_HZ < 2) begin : g_bad_clk_hz
            $error("tick_prescaler: CLK_HZ must be even and >= 2");
        end
    endgenerate

    logic [CNT_W-1:0] cnt;
    logic             half_pre;

    // wrap is the unregistered terminal count so the countdown moves in step with second_elapsed
    assign wrap     = enable && (cnt == LAST);
    assign half_pre = enable && ((cnt == HALF_LAST) || (cnt == LAST));

    always_ff @(posedge clk or negedge async_nreset) begin
        if (!async_nreset) begin
            cnt                 <= '0;
            half_second_elapsed <= 1'b0;
            second_elapsed      <= 1'b0;
        end else if (sync_clear) begin
            cnt                 <= '0;
            half_second_elapsed <= 1'b0;
            second_elapsed      <= 1'b0;
        end else begin
            half_second_elapsed <= half_pre;
            second_elapsed      <= wrap;
            if (enable) begin
                cnt <= wrap ? '0 : cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/countdown_timer.sv
// rtl/countdown_timer.sv - loadable seconds countdown with warning window and expiry
`timescale 1ns/1ps
module countdown_timer
    import timer_pkg::*;
#(
    parameter int CLK_HZ   = CLK_HZ_DEFAULT,
    parameter int SEC_W    = SEC_W_DEFAULT,
    parameter int WARN_SEC = 10
) (
    input  logic             clk,
    input  logic             async_nreset,
    input  logic             enable,
    input  logic             clear,
    input  logic             load,
    input  logic [SEC_W-1:0] load_value,
    output logic             half_second_elapsed,
    output logic             second_elapsed,
    output logic [SEC_W-1:0] seconds_left,
    output logic             warn,
    output logic             done,
    output logic             expired
);

    logic wrap;

    tick_prescaler #(
        .CLK_HZ(CLK_HZ)
    ) u_prescaler (
        .clk                (clk),
        .async_nreset       (async_nreset),
        .enable             (enable),
        .sync_clear         (clear | load),
        .half_second_elapsed(half_second_elapsed),
        .second_elapsed     (second_elapsed),
        .wrap               (wrap)
    );

    always_ff @(posedge clk or negedge async_nreset) begin
        if (!async_nreset) begin
            seconds_left <= '0;
            done         <= 1'b0;
            expired      <= 1'b0;
        end else if (clear) begin
            seconds_left <= '0;
            done         <= 1'b0;
            expired      <= 1'b0;
        end else if (load) begin
            seconds_left <= load_value;
            done         <= 1'b0;
            expired      <= 1'b0;
        end else begin
            done <= 1'b0;
            // holds at zero: no wrap, and a zero load never reaches the 1->0 step
            if (wrap && (seconds_left != '0)) begin
                seconds_left <= seconds_left - SEC_W'(1);
                if (seconds_left == SEC_W'(1)) begin
                    done    <= 1'b1;
                    expired <= 1'b1;
                end
            end
        end
    end

    assign warn = (seconds_left != '0) && (seconds_left <= SEC_W'(WARN_SEC));

endmodule

// File: tb/tb_countdown_timer.sv
// tb/tb_countdown_timer.sv - self-checking bench for countdown_timer
`timescale 1ns/1ps
module tb_countdown_timer;

    localparam int HZ = 4;
    localparam int SW = 8;
    localparam int WS = 2;

    logic          clk;
    logic          async_nreset;
    logic          enable;
    logic          clear;
    logic          load;
    logic [SW-1:0] load_value;
    logic          half_second_elapsed;
    logic          second_elapsed;
    logic [SW-1:0] seconds_left;
    logic          warn;
    logic          done;
    logic          expired;

    int errors = 0;
    int checks = 0;
    bit model_on = 0;

    // reference: enabled edges since the last clear/load, and the loaded value
    int e  = 0;
    int lv = 0;
    bit m_half, m_sec, m_done;

    countdown_timer #(.CLK_HZ(HZ), .SEC_W(SW), .WARN_SEC(WS)) dut (
        .clk                (clk),
        .async_nreset       (async_nreset),
        .enable             (enable),
        .clear              (clear),
        .load               (load),
        .load_value         (load_value),
        .half_second_elapsed(half_second_elapsed),
        .second_elapsed     (second_elapsed),
        .seconds_left       (seconds_left),
        .warn               (warn),
        .done               (done),
        .expired            (expired)
    );

    initial begin
        clk = 1'b1;
        forever #1 clk = ~clk;
    end

    function automatic int exp_secs();
        int s;
        s = lv - e / HZ;
        return (s < 0) ? 0 : s;
    endfunction

    function automatic bit exp_expired();
        return (lv > 0) && (e / HZ >= lv);
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk or negedge async_nreset) begin
        if (!async_nreset) begin
            e = 0; lv = 0; m_half = 0; m_sec = 0; m_done = 0;
        end else if (clear) begin
            e = 0; lv = 0; m_half = 0; m_sec = 0; m_done = 0;
        end else if (load) begin
            e = 0; lv = int'(load_value); m_half = 0; m_sec = 0; m_done = 0;
        end else if (enable) begin
            e++;
            m_half = (e % (HZ / 2)) == 0;
            m_sec  = (e % HZ) == 0;
            m_done = (e % HZ == 0) && (lv > 0) && (e / HZ == lv);
        end else begin
            m_half = 0; m_sec = 0; m_done = 0;
        end
    end

    always @(negedge clk) begin
        if (model_on) begin
            int s;
            s = exp_secs();
            check("half", int'(half_second_elapsed), int'(m_half));
            check("second", int'(second_elapsed), int'(m_sec));
            check("seconds_left", int'(seconds_left), s);
            check("warn", int'(warn), int'(s > 0 && s <= WS));
            check("done", int'(done), int'(m_done));
            check("expired", int'(expired), int'(exp_expired()));
        end
    end

    task automatic edges(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_load(input int v);
        load_value = SW'(v);
        load = 1'b1;
        edges(1);
        load = 1'b0;
    endtask

    initial begin
        int k, gap, half_cnt, done_cnt;
        async_nreset = 1'b0; enable = 1'b0; clear = 1'b0; load = 1'b0; load_value = '0;
        #0.5;
        check("reset_secs", int'(seconds_left), 0);
        check("reset_flags", int'({half_second_elapsed, second_elapsed, warn, done, expired}), 0);
        #4.5;
        async_nreset = 1'b1;
        model_on = 1;

        // free-running ticks with an idle countdown
        clear = 1'b1; edges(1); clear = 1'b0;
        enable = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            edges(1);
            check("lit_half", int'(half_second_elapsed), int'(i % 2 == 0));
            check("lit_second", int'(second_elapsed), int'(i % 4 == 0));
            check("lit_idle_done", int'(done), 0);
        end

        // 3 -> 0 countdown
        do_load(3);
        check("lit_load3", int'(seconds_left), 3);
        check("lit_warn3", int'(warn), 0);
        for (int i = 1; i <= 12; i++) begin
            edges(1);
            if (i == 4)  begin check("lit_s2", int'(seconds_left), 2); check("lit_w2", int'(warn), 1); end
            if (i == 8)  begin check("lit_s1", int'(seconds_left), 1); check("lit_w1", int'(warn), 1); end
            if (i == 12) begin
                check("lit_s0", int'(seconds_left), 0);
                check("lit_done", int'(done), 1);
                check("lit_expired", int'(expired), 1);
                check("lit_w0", int'(warn), 0);
            end
        end
        edges(5);
        check("lit_done_once", int'(done), 0);
        check("lit_expired_hold", int'(expired), 1);

        // enable dropped for 7 cycles mid-second
        do_load(5);
        edges(2);
        enable = 1'b0;
        edges(7);
        check("lit_frozen", int'(seconds_left), 5);
        enable = 1'b1;
        gap = 9;
        k = 0;
        while (!second_elapsed && k < 30) begin
            edges(1);
            gap++;
            k++;
        end
        check("lit_second_delay", gap, 11);
        check("lit_after_delay", int'(seconds_left), 4);

        // clear beats load, then reload while expired
        do_load(5);
        load_value = 8'd9; load = 1'b1; clear = 1'b1;
        edges(1);
        load = 1'b0; clear = 1'b0;
        check("lit_clear_wins", int'(seconds_left), 0);
        do_load(1);
        edges(4);
        check("lit_exp_before_reload", int'(expired), 1);
        do_load(5);
        check("lit_reload_expired", int'(expired), 0);
        edges(3);
        check("lit_reload_3", int'(seconds_left), 5);
        edges(1);
        check("lit_reload_4", int'(seconds_left), 4);

        // zero load stays idle while ticks run
        do_load(0);
        half_cnt = 0; done_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            edges(1);
            half_cnt += int'(half_second_elapsed);
            done_cnt += int'(done);
        end
        check("lit_zero_halves", half_cnt, 4);
        check("lit_zero_done", done_cnt, 0);
        check("lit_zero_expired", int'(expired), 0);

        // asynchronous reset one edge before expiry
        do_load(1);
        edges(3);
        #0.5 async_nreset = 1'b0;
        #0.1;
        check("lit_async_secs", int'(seconds_left), 0);
        check("lit_async_flags", int'({half_second_elapsed, second_elapsed, warn, done, expired}), 0);
        #0.2 async_nreset = 1'b1;
        done_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            edges(1);
            done_cnt += int'(done);
        end
        check("lit_async_no_done", done_cnt, 0);

        model_on = 0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
